// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared state type, idle strobe levels and counter sizing for the RTC bus sequencer
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_A_STB,
    S_A_GAP,
    S_D_STB,
    S_D_GAP
  } state_e;

  localparam logic STB_IDLE = 1'b1;
  localparam logic AOD_IDLE = 1'b1;

  // Phase counter must hold the longer of the strobe and gap lengths minus one.
  function automatic int cnt_width(input int t_pulse, input int t_gap);
    int longest;
    longest = (t_pulse > t_gap) ? t_pulse : t_gap;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/rtc_bus_arbiter.sv
// rtl/rtc_bus_arbiter.sv - fixed-priority or round-robin winner selection for the RTC bus requesters
module rtc_bus_arbiter #(
  parameter int N_CH    = 5,
  parameter int RR_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         req_i,
  input  logic                    upd_i,
  input  logic [$clog2(N_CH)-1:0] upd_idx_i,
  output logic                    gnt_vld_o,
  output logic [$clog2(N_CH)-1:0] gnt_idx_o
);

  localparam int IDX_W = $clog2(N_CH);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // The pointer only moves when a transaction is acknowledged, never at grant time.
  assign ptr_d = upd_i ? upd_idx_i : ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= IDX_W'(N_CH - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin : sel
    logic             found;
    logic [IDX_W-1:0] cand;
    found     = 1'b0;
    cand      = '0;
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (RR_MODE != 0) begin
        cand = IDX_W'((int'(ptr_q) + 1 + k) % N_CH);
      end else begin
        cand = IDX_W'(k);
      end
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        gnt_vld_o = 1'b1;
        gnt_idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/rtc_bus_sequencer.sv
// rtl/rtc_bus_sequencer.sv - arbitrated two-phase master for the RTC multiplexed address/data bus
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int N_CH    = 5,
  parameter int DATA_W  = 8,
  parameter int T_PULSE = 4,
  parameter int T_GAP   = 2,
  parameter int RR_MODE = 0
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic [N_CH-1:0]          req,
  input  logic [N_CH-1:0]          we,
  input  logic [N_CH*DATA_W-1:0]   addr,
  input  logic [N_CH*DATA_W-1:0]   wdata,
  output logic [N_CH-1:0]          ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  output logic [$clog2(N_CH)-1:0]  grant_id,
  output logic [DATA_W-1:0]        bus_out,
  output logic                     bus_oe,
  input  logic [DATA_W-1:0]        bus_in,
  output logic                     ChipSelect,
  output logic                     Read,
  output logic                     Write,
  output logic                     AoD
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int CNT_W = cnt_width(T_PULSE, T_GAP);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(T_GAP - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               cs_q, rd_q, wr_q, aod_q, oe_q, busy_q, we_q;
  logic [DATA_W-1:0]  bus_q, rdata_q, wdata_q;
  logic [N_CH-1:0]    ack_q;
  logic [IDX_W-1:0]   gid_q;

  logic               gnt_vld;
  logic [IDX_W-1:0]   gnt_idx;
  logic [DATA_W-1:0]  sel_addr, sel_wdata;

  assign sel_addr  = addr[gnt_idx*DATA_W +: DATA_W];
  assign sel_wdata = wdata[gnt_idx*DATA_W +: DATA_W];

  rtc_bus_arbiter #(
    .N_CH    (N_CH),
    .RR_MODE (RR_MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (Reset),
    .req_i     (req),
    .upd_i     (|ack_q),
    .upd_idx_i (gid_q),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  // Outputs are set on the edge that enters each phase so every pin comes straight from a flop.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cs_q    <= STB_IDLE;
      rd_q    <= STB_IDLE;
      wr_q    <= STB_IDLE;
      aod_q   <= AOD_IDLE;
      oe_q    <= 1'b0;
      bus_q   <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      gid_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            state_q <= S_A_STB;
            cnt_q   <= PULSE_LAST;
            gid_q   <= gnt_idx;
            we_q    <= we[gnt_idx];
            wdata_q <= sel_wdata;
            bus_q   <= sel_addr;
            oe_q    <= 1'b1;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            aod_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_A_STB: begin
          if (cnt_q == '0) begin
            state_q <= S_A_GAP;
            cnt_q   <= GAP_LAST;
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_A_GAP: begin
          if (cnt_q == '0) begin
            state_q <= S_D_STB;
            cnt_q   <= PULSE_LAST;
            cs_q    <= 1'b0;
            aod_q   <= 1'b1;
            if (we_q) begin
              wr_q  <= 1'b0;
              bus_q <= wdata_q;
            end else begin
              rd_q <= 1'b0;
              oe_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_D_STB: begin
          if (cnt_q == '0) begin
            state_q <= S_D_GAP;
            cnt_q   <= GAP_LAST;
            cs_q    <= 1'b1;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            oe_q    <= we_q;
            if (!we_q) begin
              rdata_q <= bus_in;
            end
            if (T_GAP == 1) begin
              ack_q[gid_q] <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_D_GAP: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            oe_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              ack_q[gid_q] <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign busy       = busy_q;
  assign grant_id   = gid_q;
  assign bus_out    = bus_q;
  assign bus_oe     = oe_q;
  assign ChipSelect = cs_q;
  assign Read       = rd_q;
  assign Write      = wr_q;
  assign AoD        = aod_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb/tb_rtc_bus_sequencer.sv - fixed-priority and round-robin sequencers against a cycle-position reference model
module tb_rtc_bus_sequencer;

  localparam int N    = 5;
  localparam int W    = 8;
  localparam int P    = 4;
  localparam int G    = 2;
  localparam int TEND = 2 * (P + G);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   we  = '0;
  logic [N*W-1:0] addr  = '0;
  logic [N*W-1:0] wdata = '0;
  logic [W-1:0]   bus_in = '0;

  logic [N-1:0]   ack_w     [2];
  logic [W-1:0]   rdata_w   [2];
  logic           busy_w    [2];
  logic [2:0]     gid_w     [2];
  logic [W-1:0]   bus_out_w [2];
  logic           oe_w      [2];
  logic           cs_w      [2];
  logic           rd_w      [2];
  logic           wr_w      [2];
  logic           aod_w     [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance 0 is fixed priority, instance 1 round-robin; both see the same stimulus.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    rtc_bus_sequencer #(
      .N_CH(N), .DATA_W(W), .T_PULSE(P), .T_GAP(G), .RR_MODE(g)
    ) u_dut (
      .clk(clk), .Reset(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack_w[g]), .rdata(rdata_w[g]), .busy(busy_w[g]), .grant_id(gid_w[g]),
      .bus_out(bus_out_w[g]), .bus_oe(oe_w[g]), .bus_in(bus_in),
      .ChipSelect(cs_w[g]), .Read(rd_w[g]), .Write(wr_w[g]), .AoD(aod_w[g])
    );
  end

  // Reference: t = cycles since grant (0 when idle); every pin follows from t alone.
  int           t_m    [2] = '{0, 0};
  int           win_m  [2] = '{0, 0};
  int           ptr_m  [2] = '{N-1, N-1};
  logic         we_m   [2] = '{1'b0, 1'b0};
  logic [W-1:0] addr_m [2] = '{8'h00, 8'h00};
  logic [W-1:0] wd_m   [2] = '{8'h00, 8'h00};
  logic [W-1:0] rd_m   [2] = '{8'h00, 8'h00};

  function automatic int pick(input int m);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m == 1) ? (ptr_m[m] + 1 + k) % N : k;
      if (req[c]) return c;
    end
    return 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        t_m[m] = 0; win_m[m] = 0; ptr_m[m] = N - 1; rd_m[m] = '0;
      end else if (t_m[m] == 0) begin
        if (req != '0) begin
          win_m[m]  = pick(m);
          we_m[m]   = we[win_m[m]];
          addr_m[m] = addr[win_m[m]*W +: W];
          wd_m[m]   = wdata[win_m[m]*W +: W];
          t_m[m]    = 1;
        end
      end else if (t_m[m] == TEND) begin
        t_m[m]   = 0;
        ptr_m[m] = win_m[m];
      end else begin
        if (t_m[m] == 2*P + G && !we_m[m]) rd_m[m] = bus_in;
        t_m[m]++;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int m = 0; m < 2; m++) begin
      int           tt;
      logic         cs, rd, wr, aod, oe;
      logic [W-1:0] bus_e;
      logic [N-1:0] ack_e;
      tt = t_m[m];
      cs = 1'b1; rd = 1'b1; wr = 1'b1; aod = 1'b1; oe = 1'b0;
      bus_e = (tt <= P + G) ? addr_m[m] : wd_m[m];
      if (tt >= 1 && tt <= P) begin
        cs = 1'b0; wr = 1'b0; aod = 1'b0; oe = 1'b1;
      end else if (tt > P && tt <= P + G) begin
        aod = 1'b0; oe = 1'b1;
      end else if (tt > P + G && tt <= 2*P + G) begin
        cs = 1'b0;
        if (we_m[m]) begin wr = 1'b0; oe = 1'b1; end
        else rd = 1'b0;
      end else if (tt > 2*P + G) begin
        oe = we_m[m];
      end
      ack_e = (tt == TEND) ? (N'(1) << win_m[m]) : '0;
      check_val($sformatf("ctl%0d_t%0d", m, tt),
                {cs_w[m], rd_w[m], wr_w[m], aod_w[m], oe_w[m], busy_w[m]},
                {cs, rd, wr, aod, oe, (tt != 0)});
      check_val($sformatf("ack%0d_t%0d", m, tt), ack_w[m], ack_e);
      check_val($sformatf("gid%0d", m), gid_w[m], win_m[m]);
      check_val($sformatf("rdata%0d", m), rdata_w[m], rd_m[m]);
      if (oe) check_val($sformatf("bus%0d_t%0d", m, tt), bus_out_w[m], bus_e);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_ack(input int m, input int ch, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!ack_w[m][ch] && n < 40);
  endtask

  initial begin
    int n, n2, cnt, idx;

    repeat (2) cyc();
    for (int m = 0; m < 2; m++) check_val("rst_bus", bus_out_w[m], 0);
    rst = 1'b0;
    bus_in = 8'h37;

    // Write from channel 2
    req = 5'b00100; we = 5'b00100;
    addr[2*W +: W] = 8'h21; wdata[2*W +: W] = 8'h45;
    wait_ack(0, 2, n);
    check_val("wr_ack_cycle", n, TEND);
    req = '0;
    cyc();

    // Read from channel 4
    req = 5'b10000; we = 5'b00000; addr[4*W +: W] = 8'h10;
    wait_ack(0, 4, n);
    check_val("rd_ack_cycle", n, TEND);
    check_val("rd_data", rdata_w[0], 8'h37);
    req = '0; bus_in = 8'hc4;
    repeat (3) cyc();
    check_val("rd_hold", rdata_w[0], 8'h37);

    // Simultaneous requests on channels 1 and 3
    req = 5'b01010; addr[1*W +: W] = 8'h11; addr[3*W +: W] = 8'h33;
    wait_ack(0, 1, n);
    check_val("fp_first", gid_w[0], 1);
    req[1] = 1'b0;
    wait_ack(0, 3, n2);
    check_val("fp_second", gid_w[0], 3);
    check_val("fp_spacing", n2, TEND + 1);
    req = '0;
    cyc();

    // Request withdrawn during the address gap
    req = 5'b01000; we = 5'b01000;
    n = 0;
    while (t_m[0] != P + 1 && n < 40) begin cyc(); n++; end
    req = '0;
    cnt = 0;
    repeat (30) begin cyc(); cnt += int'(ack_w[0][3]); end
    check_val("drop_acks", cnt, 1);

    // Reset in the middle of a write data strobe
    req = 5'b00001; we = 5'b00001; wdata[0 +: W] = 8'h5a;
    n = 0;
    while (t_m[0] != P + G + 2 && n < 40) begin cyc(); n++; end
    rst = 1'b1;
    #1;
    for (int m = 0; m < 2; m++)
      check_val("rst_async", {cs_w[m], rd_w[m], wr_w[m], oe_w[m], busy_w[m], ack_w[m]},
                {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000});
    check_outputs();
    cyc();
    rst = 1'b0;
    wait_ack(0, 0, n);
    check_val("rst_restart", n, TEND);
    req = '0;
    cyc();

    // All channels requesting after a fresh reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req = 5'b11111; we = 5'b10101;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      do begin cyc(); n++; end while (ack_w[1] == '0 && n < 40);
      idx = -1;
      for (int c = 0; c < N; c++) if (ack_w[1][c]) idx = c;
      check_val($sformatf("rr_order%0d", i), idx, i % N);
    end
    req = '0;
    cyc();

    // Random traffic, including fields that change after the grant
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if ($urandom_range(0, 3) == 0) req[$urandom_range(0, N-1)] ^= 1'b1;
      we     = N'($urandom);
      addr   = {$urandom, $urandom};
      wdata  = {$urandom, $urandom};
      bus_in = W'($urandom);
      rst    = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Parametrised, multi-channel master for the RTC's multiplexed address/data bus. It replaces the ad-hoc per-cycle address/data muxing between init, reset, write, read-poll and chronometer sources with a proper arbiter plus a timed two-phase bus sequencer. Each requester gets a req/ack handshake. `Protocolo_rtc`-style strobe generation (ChipSelect, Read, Write, AoD) is produced here with configurable pulse and gap lengths. The block sits between the control state machines and the board-level tri-state on `DATA_ADDRESS`.

## Interface
- `N_CH`, 5: number of requester channels (≥2).
- `DATA_W`, 8: address and data width.
- `T_PULSE`, 4: strobe-low length in clk cycles (≥1).
- `T_GAP`, 2: strobe-high hold/recovery length after each strobe (≥1).
- `RR_MODE`, 0: 0 = fixed priority (channel 0 highest), 1 = round-robin.

- `clk` in 1: system clock.
- `Reset` in 1: asynchronous, active-high reset.
- `req` in N_CH: per-channel request, level; held until `ack`.
- `we` in N_CH: per-channel 1 = write, 0 = read.
- `addr` in N_CH*DATA_W: per-channel RTC register address, channel i at bits [i*DATA_W +: DATA_W].
- `wdata` in N_CH*DATA_W: per-channel write data, same packing.
- `ack` out N_CH: one-cycle completion pulse to the granted channel.
- `rdata` out DATA_W: read data. Valid in the `ack` cycle of a read and held until the next read completes.
- `busy` out 1: high from grant until `ack` inclusive.
- `grant_id` out $clog2(N_CH): index of the current/last granted channel.
- `bus_out` out DATA_W: value driven onto `DATA_ADDRESS`.
- `bus_oe` out 1: tri-state enable for `bus_out`.
- `bus_in` in DATA_W: value read from `DATA_ADDRESS`.
- `ChipSelect`, `Read`, `Write`, `AoD` out 1 each: RTC controls, active-low, except AoD (0 = address phase, 1 = data phase).

## Operation
- States: IDLE, A_STB, A_GAP, D_STB, D_GAP. A counter of width $clog2(max(T_PULSE,T_GAP)+1) times each state.
- IDLE:
  - If any `req` is high, select a winner and latch its `we`, `addr`, `wdata` and index.
  - Set `busy`, then go to A_STB.
  - Requests that arrive after the latch are ignored until the next IDLE.
- A_STB, T_PULSE cycles: ChipSelect=0, Write=0, AoD=0, `bus_out`=addr, `bus_oe`=1.
- A_GAP, T_GAP cycles: ChipSelect=1, Write=1, AoD=0. `bus_out` holds the address with `bus_oe`=1.
- D_STB, T_PULSE cycles: ChipSelect=0, AoD=1.
  - Write: Write=0, `bus_out`=wdata, `bus_oe`=1.
  - Read: Read=0, `bus_oe`=0. `bus_in` is sampled into `rdata` on the last D_STB cycle.
- D_GAP, T_GAP cycles: strobes high, AoD=1, `bus_oe` equal to `we`. `ack[grant]` pulses on the last D_GAP cycle; next state is IDLE.
- Fixed priority: lowest-index active `req` wins.
- Round-robin:
  - Search starts at `last_grant+1` modulo N_CH and wraps.
  - The pointer updates only on `ack`.
  - After reset the search starts at channel 0.
- Dropping `req` mid-transaction does not abort; the transaction completes and `ack` still pulses.
- A `req` still high in the cycle after `ack` starts a new transaction.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE.
  - ChipSelect, Read, Write = 1; AoD = 1.
  - `bus_oe`=0, `bus_out`=0, `rdata`=0, `ack`=0, `busy`=0, `grant_id`=0.
  - Round-robin pointer = N_CH-1.
- Latency:
  - `req` sampled in IDLE at cycle 0 → A_STB strobes low at cycle 1.
  - `ack` at cycle 2*(T_PULSE+T_GAP).
  - Back-to-back transactions are separated by exactly one IDLE cycle.
- Reset asserted mid-transaction forces the reset values immediately (async). No `ack` is issued and the channel must re-request.
- Simultaneous requests: exactly one grant, and no `ack` goes to a non-granted channel.

## Structure
- `rtc_bus_pkg`: state enum, idle strobe constants, and a `clog2`-based counter-width helper.
- One sub-module, `rtc_bus_arbiter`. It holds the combinational request mask, grant selection and round-robin pointer register, parametrised by N_CH and RR_MODE.
- The top-level `inout DATA_ADDRESS` tri-state stays outside this block.

## Test plan
- Write: ch2 `we`=1, addr=0x21, wdata=0x45, T_PULSE=4, T_GAP=2.
  - AoD=0 and ChipSelect/Write low for 4 cycles with `bus_out`=0x21.
  - Then 2 gap cycles, then Write low for 4 cycles with `bus_out`=0x45.
  - `ack[2]` at cycle 12; Read never low.
- Read: ch4 `we`=0, addr=0x10, model drives `bus_in`=0x37 during D_STB.
  - `bus_oe`=0 in the data phase.
  - `rdata`=0x37 in the `ack[4]` cycle and held afterward.
- Fixed priority: ch1 and ch3 `req` together.
  - ch1 is served first; ch3 is served after one IDLE cycle.
  - `grant_id` reads 1, then 3.
- Round-robin, RR_MODE=1: all 5 channels hold `req`.
  - Grant order is 0,1,2,3,4,0; each channel gets exactly one `ack` per 5 transactions.
- Reset mid-D_STB of a write:
  - Strobes go to 1 and `bus_oe` to 0 asynchronously; no `ack`.
  - After release, a held `req` restarts from A_STB.
- `req` dropped during A_GAP: the transaction completes and `ack` pulses once. No second transaction follows.
